// File: rtl/hyper_txn_sequencer.sv
// HyperBus transaction sequencer: decodes requests against CS regions and issues PHY chunks.
// Optional macro HYPER_BURST_SPLIT_EN enables chunk splitting by cfg_t_cs_max_i and region end.
module hyper_txn_sequencer #(
    parameter int unsigned NR_CS     = 2,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic                  req_write_i,
    input  logic [31:0]           cfg_t_cs_max_i,
    input  logic [31:0]           cfg_t_rwr_i,
    input  logic [64*NR_CS-1:0]   cfg_addr_mapping_i,
    output logic                  phy_valid_o,
    input  logic                  phy_ready_i,
    output logic [31:0]           phy_addr_o,
    output logic [LEN_WIDTH-1:0]  phy_len_o,
    output logic                  phy_write_o,
    output logic [NR_CS-1:0]      phy_cs_o,
    input  logic                  phy_done_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_error_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RECOVER,
        S_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic                   write_q, write_d;
    logic [31:0]            rwr_q, rwr_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   req_ready_q, req_ready_d;
    logic                   phy_valid_q, phy_valid_d;
    logic [31:0]            phy_addr_q, phy_addr_d;
    logic [LEN_WIDTH-1:0]   phy_len_q, phy_len_d;
    logic                   phy_write_q, phy_write_d;
    logic [NR_CS-1:0]       phy_cs_q, phy_cs_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_error_q, rsp_error_d;

    logic                   hit_c;
    logic [NR_CS-1:0]       hit_cs_c;
    logic [31:0]            hit_start_c, hit_end_c;
    logic [32:0]            left_c;
    logic [LEN_WIDTH-1:0]   chunk_c;
    logic                   fits_c;

    // Region decode: lowest-index CS containing the current address wins.
    always_comb begin
        hit_c       = 1'b0;
        hit_cs_c    = '0;
        hit_start_c = '0;
        hit_end_c   = '0;
        for (int unsigned i = 0; i < NR_CS; i++) begin
            if (!hit_c
                && cfg_addr_mapping_i[64*i +: 32] <= addr_q
                && addr_q <= cfg_addr_mapping_i[64*i+32 +: 32]) begin
                hit_c       = 1'b1;
                hit_cs_c    = NR_CS'(1) << i;
                hit_start_c = cfg_addr_mapping_i[64*i +: 32];
                hit_end_c   = cfg_addr_mapping_i[64*i+32 +: 32];
            end
        end
    end

`ifdef HYPER_BURST_SPLIT_EN
    logic [31:0] cs_max_c;

    // Chunk = min(remaining, cs_max (0 -> 1), words left in region), in 33 bits.
    always_comb begin
        left_c   = 33'(hit_end_c) - 33'(addr_q) + 33'd1;
        cs_max_c = (cfg_t_cs_max_i == 32'd0) ? 32'd1 : cfg_t_cs_max_i;
        chunk_c  = rem_q;
        if (33'(cs_max_c) < 33'(chunk_c)) chunk_c = LEN_WIDTH'(cs_max_c);
        if (left_c < 33'(chunk_c)) chunk_c = LEN_WIDTH'(left_c);
        fits_c   = 1'b1;
    end
`else
    logic unused_cs_max;
    assign unused_cs_max = ^cfg_t_cs_max_i;

    // Whole request in one chunk; it must not run past the region end.
    always_comb begin
        left_c  = 33'(hit_end_c) - 33'(addr_q) + 33'd1;
        chunk_c = rem_q;
        fits_c  = (33'(rem_q) <= left_c);
    end
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        write_d     = write_q;
        rwr_d       = rwr_q;
        cnt_d       = cnt_q;
        phy_addr_d  = phy_addr_q;
        phy_len_d   = phy_len_q;
        phy_write_d = phy_write_q;
        phy_cs_d    = phy_cs_q;
        rsp_error_d = rsp_error_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    rem_d       = req_len_i;
                    write_d     = req_write_i;
                    rsp_error_d = 1'b0;
                    state_d     = (req_len_i == '0) ? S_RESP : S_DECODE;
                end
            end
            S_DECODE: begin
                // Config is sampled only here so mid-chunk changes hit the next chunk.
                rwr_d = cfg_t_rwr_i;
                if (!hit_c || !fits_c) begin
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    phy_addr_d  = addr_q - hit_start_c;
                    phy_len_d   = chunk_c;
                    phy_write_d = write_q;
                    phy_cs_d    = hit_cs_c;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (phy_ready_i) begin
                    addr_d  = addr_q + 32'(phy_len_q);
                    rem_d   = rem_q - phy_len_q;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (phy_done_i) begin
                    cnt_d   = (rwr_q == 32'd0) ? 32'd1 : rwr_q;
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (cnt_q <= 32'd1) begin
                    rsp_error_d = 1'b0;
                    state_d     = (rem_q != '0) ? S_DECODE : S_RESP;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_error_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
        phy_valid_d = (state_d == S_ISSUE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            write_q     <= 1'b0;
            rwr_q       <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            phy_valid_q <= 1'b0;
            phy_addr_q  <= '0;
            phy_len_q   <= '0;
            phy_write_q <= 1'b0;
            phy_cs_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            write_q     <= write_d;
            rwr_q       <= rwr_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            phy_valid_q <= phy_valid_d;
            phy_addr_q  <= phy_addr_d;
            phy_len_q   <= phy_len_d;
            phy_write_q <= phy_write_d;
            phy_cs_q    <= phy_cs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign phy_valid_o = phy_valid_q;
    assign phy_addr_o  = phy_addr_q;
    assign phy_len_o   = phy_len_q;
    assign phy_write_o = phy_write_q;
    assign phy_cs_o    = phy_cs_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_hyper_txn_sequencer.sv
// Directed self-checking bench for hyper_txn_sequencer (NR_CS=2, LEN_WIDTH=16).
module tb_hyper_txn_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic [15:0]  req_len = '0;
    logic         req_write = 1'b0;
    logic [31:0]  cs_max = 32'd665;
    logic [31:0]  rwr = 32'd6;
    logic [127:0] addr_map = {32'h007F_FFFF, 32'h0040_0000, 32'h003F_FFFF, 32'h0000_0000};
    logic         phy_valid;
    logic         phy_ready = 1'b0;
    logic [31:0]  phy_addr;
    logic [15:0]  phy_len;
    logic         phy_write;
    logic [1:0]   phy_cs;
    logic         phy_done = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_error;

    int total = 0;
    int bad   = 0;

    hyper_txn_sequencer #(.NR_CS(2), .LEN_WIDTH(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_addr_i         (req_addr),
        .req_len_i          (req_len),
        .req_write_i        (req_write),
        .cfg_t_cs_max_i     (cs_max),
        .cfg_t_rwr_i        (rwr),
        .cfg_addr_mapping_i (addr_map),
        .phy_valid_o        (phy_valid),
        .phy_ready_i        (phy_ready),
        .phy_addr_o         (phy_addr),
        .phy_len_o          (phy_len),
        .phy_write_o        (phy_write),
        .phy_cs_o           (phy_cs),
        .phy_done_i         (phy_done),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_error_o        (rsp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_req(input string tag, input logic [31:0] a, input logic [15:0] l,
                            input logic w);
        int c = 0;
        while (req_ready !== 1'b1 && c < 20) begin tick(); c++; end
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_addr  = a;
        req_len   = l;
        req_write = w;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Wait for a chunk, check its fields, handshake, finish it, and check recovery gap.
    task automatic do_chunk(input string tag, input logic [1:0] cs, input logic [31:0] a,
                            input logic [15:0] l, input logic w);
        int c = 0;
        while (phy_valid !== 1'b1 && c < 40) begin tick(); c++; end
        chk({tag, "_phy_valid"}, 64'(phy_valid), 64'd1);
        chk({tag, "_phy_cs"},    64'(phy_cs),    64'(cs));
        chk({tag, "_phy_addr"},  64'(phy_addr),  64'(a));
        chk({tag, "_phy_len"},   64'(phy_len),   64'(l));
        chk({tag, "_phy_write"}, 64'(phy_write), 64'(w));
        phy_ready = 1'b1;
        tick();
        phy_ready = 1'b0;
        chk({tag, "_phy_valid_drop"}, 64'(phy_valid), 64'd0);
        phy_done = 1'b1;
        tick();
        phy_done = 1'b0;
        c = 0;
        while (phy_valid !== 1'b1 && rsp_valid !== 1'b1 && c < 60) begin tick(); c++; end
        chk({tag, "_gap_ge_rwr"}, 64'(c >= 6), 64'd1);
    endtask

    task automatic expect_no_phy(input string tag);
        int c = 0;
        logic saw = 1'b0;
        while (rsp_valid !== 1'b1 && c < 40) begin
            if (phy_valid === 1'b1) saw = 1'b1;
            tick();
            c++;
        end
        chk({tag, "_no_phy"}, 64'(saw), 64'd0);
    endtask

    task automatic do_rsp(input string tag, input logic err);
        int c = 0;
        while (rsp_valid !== 1'b1 && c < 40) begin tick(); c++; end
        chk({tag, "_rsp_valid"},  64'(rsp_valid), 64'd1);
        chk({tag, "_rsp_error"},  64'(rsp_error), 64'(err));
        chk({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"},   64'(rsp_valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_phy_valid", 64'(phy_valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_phy_cs",    64'(phy_cs),    64'd0);
        chk("rst_phy_addr",  64'(phy_addr),  64'd0);
        chk("rst_phy_len",   64'(phy_len),   64'd0);
        chk("rst_phy_write", 64'(phy_write), 64'd0);

        // Single write into CS1; done pulse during ISSUE must be ignored
        cs_max = 32'd665;
        send_req("r031", 32'h0040_0010, 16'd8, 1'b1);
        for (int i = 0; i < 40 && phy_valid !== 1'b1; i++) tick();
        phy_done = 1'b1;
        tick();
        phy_done = 1'b0;
        tick();
        chk("r031_hold_valid", 64'(phy_valid), 64'd1);
        chk("r031_hold_addr",  64'(phy_addr),  64'h10);
        do_chunk("r031", 2'b10, 32'h10, 16'd8, 1'b1);
        do_rsp("r031", 1'b0);

        // Address outside all regions, response held for 5 cycles
        send_req("r034a", 32'h0080_0000, 16'd4, 1'b0);
        expect_no_phy("r034a");
        for (int i = 0; i < 5; i++) begin
            chk("r036_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("r036_rsp_error", 64'(rsp_error), 64'd1);
            chk("r036_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        do_rsp("r034a", 1'b1);

        // Zero-length request
        send_req("r034b", 32'h0000_0000, 16'd0, 1'b1);
        expect_no_phy("r034b");
        do_rsp("r034b", 1'b0);

`ifdef HYPER_BURST_SPLIT_EN
        // Split by cs_max
        cs_max = 32'd4;
        send_req("r032", 32'h0, 16'd10, 1'b0);
        do_chunk("r032_c0", 2'b01, 32'h0, 16'd4, 1'b0);
        do_chunk("r032_c1", 2'b01, 32'h4, 16'd4, 1'b0);
        do_chunk("r032_c2", 2'b01, 32'h8, 16'd2, 1'b0);
        do_rsp("r032", 1'b0);

        // Split at region boundary
        cs_max = 32'd665;
        send_req("r033", 32'h003F_FFFE, 16'd4, 1'b1);
        do_chunk("r033_c0", 2'b01, 32'h003F_FFFE, 16'd2, 1'b1);
        do_chunk("r033_c1", 2'b10, 32'h0, 16'd2, 1'b1);
        do_rsp("r033", 1'b0);

        // cs_max of zero behaves as one
        cs_max = 32'd0;
        send_req("csz", 32'h5, 16'd2, 1'b0);
        do_chunk("csz_c0", 2'b01, 32'h5, 16'd1, 1'b0);
        do_chunk("csz_c1", 2'b01, 32'h6, 16'd1, 1'b0);
        do_rsp("csz", 1'b0);
`else
        // cs_max ignored: one chunk covering the whole request
        cs_max = 32'd4;
        send_req("nosplit", 32'h100, 16'd20, 1'b0);
        do_chunk("nosplit", 2'b01, 32'h100, 16'd20, 1'b0);
        do_rsp("nosplit", 1'b0);

        // Request crossing region end is rejected
        send_req("cross", 32'h003F_FFFE, 16'd4, 1'b1);
        expect_no_phy("cross");
        do_rsp("cross", 1'b1);
`endif

        // Reset in WAIT_DONE with phy_ready held, then stray done in IDLE
        cs_max = 32'd665;
        send_req("r035", 32'h0, 16'd4, 1'b0);
        for (int i = 0; i < 40 && phy_valid !== 1'b1; i++) tick();
        chk("r035_phy_valid", 64'(phy_valid), 64'd1);
        phy_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("r035_rst_phy_valid", 64'(phy_valid), 64'd0);
        chk("r035_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("r035_rst_phy_cs",    64'(phy_cs),    64'd0);
        rst = 1'b0;
        tick();
        chk("r035_idle_ready", 64'(req_ready), 64'd1);
        phy_done = 1'b1;
        tick();
        phy_done = 1'b0;
        tick();
        chk("r035_stray_ready", 64'(req_ready), 64'd1);
        chk("r035_stray_phy",   64'(phy_valid), 64'd0);
        chk("r035_stray_rsp",   64'(rsp_valid), 64'd0);
        phy_ready = 1'b0;
        send_req("r035_after", 32'h0040_0000, 16'd2, 1'b1);
        do_chunk("r035_after", 2'b10, 32'h0, 16'd2, 1'b1);
        do_rsp("r035_after", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hyper_txn_sequencer.md
HYPER_TXN_SEQUENCER -- requirements
Module: hyper_txn_sequencer

Interface
REQ-001 SHALL have parameter NR_CS, default 2: number of chip selects / address regions.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: request length width, in 16-bit words.
REQ-003 SHALL have port clk_i  in  1  clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i / req_ready_o  in/out  1/1  request handshake.
REQ-006 SHALL have port req_addr_i  in  32  start word address.
REQ-007 SHALL have port req_len_i  in  LEN_WIDTH  length in words.
REQ-008 SHALL have port req_write_i  in  1  1=write, 0=read.
REQ-009 SHALL have port cfg_t_cs_max_i  in  32  max words per chunk; 0 treated as 1.
REQ-010 SHALL have port cfg_t_rwr_i  in  32  recovery cycles between chunks.
REQ-011 SHALL have port cfg_addr_mapping_i  in  64*NR_CS  per CS i: [64i+31:64i]=start, [64i+63:64i+32]=end, inclusive.
REQ-012 SHALL have port phy_valid_o / phy_ready_i  out/in  1/1  chunk issue handshake.
REQ-013 SHALL have port phy_addr_o  out  32  chunk address, relative to region start.
REQ-014 SHALL have port phy_len_o  out  LEN_WIDTH  chunk length, words.
REQ-015 SHALL have port phy_write_o  out  1; phy_cs_o  out  NR_CS  one-hot select.
REQ-016 SHALL have port phy_done_i  in  1  single-cycle pulse: issued chunk finished.
REQ-017 SHALL have port rsp_valid_o / rsp_ready_i  out/in  1/1; rsp_error_o  out  1.

Function
REQ-018 SHALL implement states IDLE, DECODE, ISSUE, WAIT_DONE, RECOVER, RESP.
REQ-019 IDLE: req_ready_o=1 only here; on req_valid_i latch addr/len/write, go DECODE; len 0 -> RESP, error=0, no PHY issue.
REQ-020 DECODE (1 cycle): lowest-index CS with start<=addr<=end wins; no match -> RESP, error=1; match -> ISSUE.
REQ-021 Chunk length SHALL be min(remaining, cfg_t_cs_max (0->1), end-addr+1), computed with 33-bit arithmetic, no wrap.
REQ-022 ISSUE: phy_valid_o=1 with addr/len/write/cs stable until phy_ready_i; handshake -> WAIT_DONE; addr+=chunk, remaining-=chunk.
REQ-023 WAIT_DONE: phy_done_i -> RECOVER; counter loaded with max(cfg_t_rwr_i,1).
REQ-024 RECOVER: decrement per cycle; at 1 -> DECODE if remaining>0, else RESP error=0.
REQ-025 RESP: rsp_valid_o=1 held until rsp_ready_i, then IDLE; same-cycle new req not accepted (ready after return).
REQ-026 Config inputs SHALL be sampled in DECODE only; changes mid-chunk affect next chunk.
REQ-027 phy_done_i outside WAIT_DONE SHALL be ignored.

Reset
REQ-028 rst_i SHALL force IDLE in any state, including mid-chunk; outputs: req_ready_o=1 after release, phy_valid_o=0, rsp_valid_o=0, rsp_error_o=0, phy_cs_o=0, phy_addr/len/write=0.

Configuration
REQ-029 Macro HYPER_BURST_SPLIT_EN defined: chunking per REQ-021.
REQ-030 Macro undefined: chunk = remaining (cfg_t_cs_max ignored); request beyond region end -> RESP, error=1, no PHY issue.

Verification
REQ-031 NR_CS=2, map {0..3FFFFF, 400000..7FFFFF}, cs_max=665, req addr 400010 len 8 write -> one chunk, phy_cs=2'b10, phy_addr=10, len 8, rsp error=0.
REQ-032 Split EN, cs_max=4, len 10 at addr 0 -> chunks len 4,4,2 at 0,4,8; with rwr=6, >=6 cycles between phy_done and next phy_valid.
REQ-033 Split EN, addr 3FFFFE len 4 -> chunk cs0 addr 3FFFFE len 2, then cs1 addr 0 len 2.
REQ-034 addr 800000 -> no phy_valid, rsp_valid with rsp_error=1; len 0 -> rsp error=0, no phy_valid.
REQ-035 rst_i asserted in WAIT_DONE with phy_ready held -> next cycle phy_valid=0, rsp_valid=0, IDLE; stray phy_done ignored.
REQ-036 rsp_ready_i held low 5 cycles -> rsp_valid/rsp_error stable, req_ready_o=0 throughout.
